// File: rtl/rv32i_main_pkg.sv
// rtl/rv32i_main_pkg.sv - opcodes, ALU/writeback enums and immediate helpers for rv32i_main_core
package rv32i_main_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB, ALU_MUL
  } alu_op_t;

  typedef enum logic [1:0] {
    WB_ALU, WB_MEM, WB_PC4
  } wb_sel_t;

  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'b0};
  endfunction

endpackage

// File: rtl/rv32i_main_regfile.sv
// rtl/rv32i_main_regfile.sv - 32x32 register file, two async read ports, one sync write, x0 hardwired
module rv32i_main_regfile
  import rv32i_main_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs [0:31];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/rv32i_main_core.sv
// rtl/rv32i_main_core.sv - single-cycle RV32I-subset core; MAIN_MUL_EN adds the MUL instruction
module rv32i_main_core
  import rv32i_main_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_WORDS = 256,
  parameter              IMEM_FILE  = "program.hex"
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] dbg_pc,
  output logic [31:0] dbg_next_pc,
  output logic [31:0] dbg_pc_plus_4,
  output logic        dbg_sel_pc_src,
  output logic [31:0] dbg_instruction,
  output logic [31:0] dbg_alu_result
);

  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);

  // ROM image is placed into imem by the load flow from IMEM_FILE.
  logic [31:0] imem [0:IMEM_WORDS-1];
  logic [31:0] dmem [0:DMEM_WORDS-1];

  logic [31:0] pc, pc_plus_4, next_pc, instr;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;

  alu_op_t     alu_op;
  wb_sel_t     wb_sel;
  logic        src_a_pc, src_b_imm, reg_we, mem_we;
  logic        is_branch, is_jal, is_jalr, branch_taken, sel_pc_src;
  logic [31:0] imm, rs1_data, rs2_data, op_a, op_b, alu_result, mem_rdata, wb_data;

  assign instr     = imem[pc[IW+1:2]];
  assign pc_plus_4 = pc + 32'd4;
  assign opcode    = instr[6:0];
  assign rd        = instr[11:7];
  assign funct3    = instr[14:12];
  assign rs1       = instr[19:15];
  assign rs2       = instr[24:20];
  assign funct7    = instr[31:25];

  always_comb begin
    alu_op    = ALU_ADD;
    wb_sel    = WB_ALU;
    imm       = '0;
    src_a_pc  = 1'b0;
    src_b_imm = 1'b0;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000000) begin
          reg_we = 1'b1;
          case (funct3)
            3'b000:  alu_op = ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000) begin
            reg_we = 1'b1;
            alu_op = ALU_SUB;
          end else if (funct3 == 3'b101) begin
            reg_we = 1'b1;
            alu_op = ALU_SRA;
          end
        end
`ifdef MAIN_MUL_EN
        else if (funct7 == 7'b0000001 && funct3 == 3'b000) begin
          reg_we = 1'b1;
          alu_op = ALU_MUL;
        end
`endif
      end
      OP_I: begin
        imm       = imm_i(instr);
        src_b_imm = 1'b1;
        case (funct3)
          3'b000: begin reg_we = 1'b1; alu_op = ALU_ADD;  end
          3'b010: begin reg_we = 1'b1; alu_op = ALU_SLT;  end
          3'b011: begin reg_we = 1'b1; alu_op = ALU_SLTU; end
          3'b100: begin reg_we = 1'b1; alu_op = ALU_XOR;  end
          3'b110: begin reg_we = 1'b1; alu_op = ALU_OR;   end
          3'b111: begin reg_we = 1'b1; alu_op = ALU_AND;  end
          3'b001: begin
            reg_we = (funct7 == 7'b0000000);
            alu_op = ALU_SLL;
          end
          default: begin
            reg_we = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            alu_op = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
          end
        endcase
      end
      OP_LOAD: begin
        imm       = imm_i(instr);
        src_b_imm = 1'b1;
        reg_we    = (funct3 == 3'b010);
        wb_sel    = WB_MEM;
      end
      OP_STORE: begin
        imm       = imm_s(instr);
        src_b_imm = 1'b1;
        mem_we    = (funct3 == 3'b010);
      end
      OP_BRANCH: begin
        is_branch = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
        alu_op    = ALU_SUB;
      end
      OP_JAL: begin
        reg_we = 1'b1;
        wb_sel = WB_PC4;
        is_jal = 1'b1;
      end
      OP_JALR: begin
        imm       = imm_i(instr);
        src_b_imm = 1'b1;
        reg_we    = (funct3 == 3'b000);
        is_jalr   = (funct3 == 3'b000);
        wb_sel    = WB_PC4;
      end
      OP_LUI: begin
        imm       = imm_u(instr);
        src_b_imm = 1'b1;
        reg_we    = 1'b1;
        alu_op    = ALU_PASSB;
      end
      OP_AUIPC: begin
        imm       = imm_u(instr);
        src_a_pc  = 1'b1;
        src_b_imm = 1'b1;
        reg_we    = 1'b1;
      end
      default: ;
    endcase
  end

  rv32i_main_regfile u_regfile (
    .clock  (clock),
    .reset  (reset),
    .we     (reg_we),
    .waddr  (rd),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  assign op_a = src_a_pc ? pc : rs1_data;
  assign op_b = src_b_imm ? imm : rs2_data;

  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD:   alu_result = op_a + op_b;
      ALU_SUB:   alu_result = op_a - op_b;
      ALU_SLL:   alu_result = op_a << op_b[4:0];
      ALU_SLT:   alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_result = {31'd0, op_a < op_b};
      ALU_XOR:   alu_result = op_a ^ op_b;
      ALU_SRL:   alu_result = op_a >> op_b[4:0];
      ALU_SRA:   alu_result = $unsigned($signed(op_a) >>> op_b[4:0]);
      ALU_OR:    alu_result = op_a | op_b;
      ALU_AND:   alu_result = op_a & op_b;
      ALU_PASSB: alu_result = op_b;
`ifdef MAIN_MUL_EN
      ALU_MUL:   alu_result = op_a * op_b;
`endif
      default:   alu_result = '0;
    endcase
  end

  always_comb begin
    branch_taken = 1'b0;
    if (is_branch) begin
      case (funct3)
        3'b000:  branch_taken = (rs1_data == rs2_data);
        3'b001:  branch_taken = (rs1_data != rs2_data);
        3'b100:  branch_taken = ($signed(rs1_data) < $signed(rs2_data));
        default: branch_taken = ($signed(rs1_data) >= $signed(rs2_data));
      endcase
    end
  end

  always_comb begin
    next_pc    = pc_plus_4;
    sel_pc_src = 1'b0;
    if (branch_taken) begin
      next_pc    = pc + imm_b(instr);
      sel_pc_src = 1'b1;
    end else if (is_jal) begin
      next_pc    = pc + imm_j(instr);
      sel_pc_src = 1'b1;
    end else if (is_jalr) begin
      next_pc    = alu_result & ~32'd1;
      sel_pc_src = 1'b1;
    end
  end

  assign mem_rdata = dmem[alu_result[DW+1:2]];

  // Reset gates the write so a store coinciding with reset is dropped.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) dmem[alu_result[DW+1:2]] <= rs2_data;
  end

  always_comb begin
    case (wb_sel)
      WB_MEM:  wb_data = mem_rdata;
      WB_PC4:  wb_data = pc_plus_4;
      default: wb_data = alu_result;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pc <= RESET_PC;
    else       pc <= next_pc;
  end

  assign dbg_pc          = pc;
  assign dbg_next_pc     = next_pc;
  assign dbg_pc_plus_4   = pc_plus_4;
  assign dbg_sel_pc_src  = sel_pc_src;
  assign dbg_instruction = instr;
  assign dbg_alu_result  = alu_result;

endmodule

// File: tb/tb_rv32i_main_core.sv
// tb/tb_rv32i_main_core.sv - directed program bench for rv32i_main_core
module tb_rv32i_main_core;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dbg_pc, dbg_next_pc, dbg_pc_plus_4, dbg_instruction, dbg_alu_result;
  logic        dbg_sel_pc_src;

  int n_checks = 0;
  int n_errors = 0;

  rv32i_main_core dut (
    .clock           (clock),
    .reset           (reset),
    .dbg_pc          (dbg_pc),
    .dbg_next_pc     (dbg_next_pc),
    .dbg_pc_plus_4   (dbg_pc_plus_4),
    .dbg_sel_pc_src  (dbg_sel_pc_src),
    .dbg_instruction (dbg_instruction),
    .dbg_alu_result  (dbg_alu_result)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic        sel;
    logic        chk_alu;
    logic [31:0] alu;
  } row_t;

  logic [31:0] prog [0:255];
  row_t        rows [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] rdx);
    return {f7, r2, r1, f3, rdx, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rdx,
                                        input logic [6:0] op);
    return {im, r1, f3, rdx, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] r2,
                                        input logic [4:0] r1);
    return {im[11:5], r2, r1, 3'b010, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3);
    return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] rdx);
    return {im[20], im[10:1], im[11], im[19:12], rdx, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] im, input logic [4:0] rdx,
                                        input logic [6:0] op);
    return {im, rdx, op};
  endfunction

  task automatic add_row(input logic [31:0] p, input logic [31:0] n, input logic s,
                         input logic c, input logic [31:0] a);
    row_t r;
    r.pc = p; r.npc = n; r.sel = s; r.chk_alu = c; r.alu = a;
    rows.push_back(r);
  endtask

  task automatic check_row(input row_t r);
    check($sformatf("pc@%h", r.pc), dbg_pc, r.pc);
    check($sformatf("pc_plus_4@%h", r.pc), dbg_pc_plus_4, r.pc + 32'd4);
    check($sformatf("instr@%h", r.pc), dbg_instruction, prog[r.pc[9:2]]);
    check($sformatf("next_pc@%h", r.pc), dbg_next_pc, r.npc);
    check($sformatf("sel_pc_src@%h", r.pc), {31'd0, dbg_sel_pc_src}, {31'd0, r.sel});
    if (r.chk_alu) check($sformatf("alu@%h", r.pc), dbg_alu_result, r.alu);
  endtask

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [31:0] MUL_EXP =
`ifdef MAIN_MUL_EN
    32'd42;
`else
    32'd0;
`endif

  initial begin
    for (int i = 0; i < 256; i++) prog[i] = 32'h0000_0000;
    prog[8'h00 >> 2] = enc_i(12'd5,   5'd0, 3'b000, 5'd1, OPI);
    prog[8'h04 >> 2] = enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, OPI);
    prog[8'h08 >> 2] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3);
    prog[8'h0C >> 2] = enc_r(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd4);
    prog[8'h10 >> 2] = enc_b(13'd12, 5'd1, 5'd1, 3'b000);
    prog[8'h14 >> 2] = enc_i(12'd1, 5'd0, 3'b000, 5'd9, OPI);
    prog[8'h18 >> 2] = enc_i(12'd1, 5'd0, 3'b000, 5'd9, OPI);
    prog[8'h1C >> 2] = enc_r(7'b0100000, 5'd1, 5'd2, 3'b101, 5'd5);
    prog[8'h20 >> 2] = enc_j(21'd8, 5'd1);
    prog[8'h24 >> 2] = enc_i(12'd16, 5'd1, 3'b000, 5'd1, OPI);
    prog[8'h28 >> 2] = enc_i(12'd1, 5'd1, 3'b000, 5'd0, 7'b1100111);
    prog[8'h34 >> 2] = enc_b(13'd8, 5'd1, 5'd1, 3'b001);
    prog[8'h38 >> 2] = enc_i(12'h040, 5'd0, 3'b000, 5'd1, OPI);
    prog[8'h3C >> 2] = enc_i(12'h07B, 5'd0, 3'b000, 5'd2, OPI);
    prog[8'h40 >> 2] = enc_s(12'd0, 5'd2, 5'd1);
    prog[8'h44 >> 2] = enc_i(12'd0, 5'd1, 3'b010, 5'd3, 7'b0000011);
    prog[8'h48 >> 2] = enc_i(12'd1, 5'd3, 3'b000, 5'd4, OPI);
    prog[8'h4C >> 2] = enc_i(12'd9, 5'd0, 3'b000, 5'd0, OPI);
    prog[8'h50 >> 2] = enc_r(7'b0000000, 5'd0, 5'd0, 3'b000, 5'd1);
    prog[8'h54 >> 2] = enc_i(12'd7, 5'd0, 3'b000, 5'd6, OPI);
    prog[8'h58 >> 2] = enc_i(12'd6, 5'd0, 3'b000, 5'd7, OPI);
    prog[8'h5C >> 2] = enc_r(7'b0000001, 5'd7, 5'd6, 3'b000, 5'd8);
    prog[8'h60 >> 2] = enc_i(12'd0, 5'd8, 3'b000, 5'd9, OPI);
    prog[8'h64 >> 2] = enc_u(20'h12345, 5'd10, 7'b0110111);
    prog[8'h68 >> 2] = enc_u(20'h00001, 5'd11, 7'b0010111);
    prog[8'h6C >> 2] = enc_i(12'hFFF, 5'd2, 3'b011, 5'd12, OPI);
    prog[8'h70 >> 2] = enc_j(21'd0, 5'd0);
    for (int i = 0; i < 256; i++) dut.imem[i] = prog[i];

    add_row(32'h00, 32'h04, 1'b0, 1'b1, 32'h0000_0005);
    add_row(32'h04, 32'h08, 1'b0, 1'b1, 32'hFFFF_FFFD);
    add_row(32'h08, 32'h0C, 1'b0, 1'b1, 32'h0000_0002);
    add_row(32'h0C, 32'h10, 1'b0, 1'b1, 32'hFFFF_FFF8);
    add_row(32'h10, 32'h1C, 1'b1, 1'b0, 32'h0);
    add_row(32'h1C, 32'h20, 1'b0, 1'b1, 32'hFFFF_FFFF);
    add_row(32'h20, 32'h28, 1'b1, 1'b0, 32'h0);
    add_row(32'h28, 32'h24, 1'b1, 1'b1, 32'h0000_0025);
    add_row(32'h24, 32'h28, 1'b0, 1'b1, 32'h0000_0034);
    add_row(32'h28, 32'h34, 1'b1, 1'b1, 32'h0000_0035);
    add_row(32'h34, 32'h38, 1'b0, 1'b0, 32'h0);
    add_row(32'h38, 32'h3C, 1'b0, 1'b1, 32'h0000_0040);
    add_row(32'h3C, 32'h40, 1'b0, 1'b1, 32'h0000_007B);
    add_row(32'h40, 32'h44, 1'b0, 1'b1, 32'h0000_0040);
    add_row(32'h44, 32'h48, 1'b0, 1'b1, 32'h0000_0040);
    add_row(32'h48, 32'h4C, 1'b0, 1'b1, 32'h0000_007C);
    add_row(32'h4C, 32'h50, 1'b0, 1'b1, 32'h0000_0009);
    add_row(32'h50, 32'h54, 1'b0, 1'b1, 32'h0000_0000);
    add_row(32'h54, 32'h58, 1'b0, 1'b1, 32'h0000_0007);
    add_row(32'h58, 32'h5C, 1'b0, 1'b1, 32'h0000_0006);
    add_row(32'h5C, 32'h60, 1'b0, 1'b0, 32'h0);
    add_row(32'h60, 32'h64, 1'b0, 1'b1, MUL_EXP);
    add_row(32'h64, 32'h68, 1'b0, 1'b1, 32'h1234_5000);
    add_row(32'h68, 32'h6C, 1'b0, 1'b1, 32'h0000_1068);
    add_row(32'h6C, 32'h70, 1'b0, 1'b1, 32'h0000_0001);
    add_row(32'h70, 32'h70, 1'b1, 1'b0, 32'h0);

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_pc", dbg_pc, 32'h0);
    check("reset_pc_plus_4", dbg_pc_plus_4, 32'h4);
    check("reset_sel", {31'd0, dbg_sel_pc_src}, 32'd0);
    reset = 1'b0;

    foreach (rows[k]) begin
      check_row(rows[k]);
      @(negedge clock);
    end

    // Mid-run reset: pc must drop before any clock edge arrives.
    #2 reset = 1'b1;
    #1;
    check("async_reset_pc", dbg_pc, 32'h0);
    check("async_reset_pc_plus_4", dbg_pc_plus_4, 32'h4);
    @(negedge clock);
    check("held_reset_pc", dbg_pc, 32'h0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_row(rows[k]);
      @(negedge clock);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rv32i_main_core.md
Name: rv32i_main_core

Overview:
- Single-cycle RV32I-subset processor top.
- Contains the PC register, instruction ROM, 32x32 register file, ALU, branch/jump logic and data RAM.
- Retires one instruction per clock. It is the whole system: no external buses, only clock, reset and debug observation outputs.
- Simulation benches run it free for a fixed time and trace PC, next PC, instruction and ALU result every cycle.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 256, instruction ROM depth in 32-bit words; index is pc[9:2].
- DMEM_WORDS, 256, data RAM depth in 32-bit words; index is addr[9:2].
- IMEM_FILE, "program.hex", $readmemh image for the instruction ROM.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- dbg_pc, output, 32, current PC.
- dbg_next_pc, output, 32, PC value loaded at the next edge.
- dbg_pc_plus_4, output, 32, pc+4.
- dbg_sel_pc_src, output, 1, 1 = taken branch/jump target selected, 0 = pc+4.
- dbg_instruction, output, 32, instruction fetched at dbg_pc.
- dbg_alu_result, output, 32, ALU output this cycle.

Behaviour:
- Reset (async, active-high):
  - pc = RESET_PC; register file cleared to 0; data RAM is not cleared.
  - All debug outputs are combinational from pc and state, so during reset dbg_pc = RESET_PC and dbg_pc_plus_4 = RESET_PC+4.
- Fetch:
  - instruction = imem[pc[9:2]], combinational.
  - PC above the ROM range wraps via index truncation.
  - pc[1:0] is ignored.
- Supported opcodes:
  - R-type (0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - I-ALU (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - LW (0000011), SW (0100011).
  - BEQ, BNE, BLT, BGE (1100011).
  - JAL (1101111), JALR (1100111), LUI (0110111), AUIPC (0010111).
- Unsupported opcodes or funct codes execute as NOP: no register write, no memory write, pc+4.
- Immediates: I/S/B/U/J forms sign-extended per RV32I; B and J immediates have bit 0 = 0.
- Shift amount is operand B [4:0]. SRA/SRAI are arithmetic. SLT is signed; SLTU is unsigned.
- x0 reads as 0; writes to x0 are discarded.
- Register file reads are combinational. The write happens on the rising edge; a same-cycle read of the written register returns the old value.
- Writeback source:
  - ALU result for R/I/LUI/AUIPC.
  - Memory word for LW.
  - pc+4 for JAL/JALR.
- Data memory:
  - Combinational read; write on the rising edge when SW.
  - Word-aligned only; addr[1:0] is ignored.
- Next PC:
  - Branch taken: pc+immB, sel_pc_src=1.
  - JAL: pc+immJ, sel_pc_src=1.
  - JALR: (rs1+immI) & ~1, sel_pc_src=1.
  - Otherwise: pc+4, sel_pc_src=0.
- All arithmetic is modulo 2^32, including PC wrap at 32'hFFFF_FFFC+4 = 0.
- Reset asserted mid-program: pc returns to RESET_PC asynchronously and registers clear. A store in flight on that edge is suppressed.

Optional Feature:
- MAIN_MUL_EN:
  - Defined: R-type funct7=0000001 with funct3=000 (MUL) writes the low 32 bits of rs1*rs2.
  - Undefined: that encoding is treated as an unsupported NOP.

Decomposition:
- Package rv32i_main_pkg holds:
  - Opcode localparams.
  - ALU-op enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB, MUL).
  - Writeback-select enum.
- One sub-module, rv32i_main_regfile: 32x32, 2 async read ports, 1 sync write port, async clear, x0 hardwired.
- ALU, decoder and memories stay inline in the top.

Test Plan:
- Reset: hold reset 2 cycles with RESET_PC=0 -> dbg_pc=0, dbg_pc_plus_4=4, dbg_sel_pc_src=0; after release PC steps 0,4,8 on successive edges.
- Arithmetic: ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x2,x1; SRA x5,x2,x1 -> alu_result sequence 5, FFFFFFFD, 2, FFFFFFF8, FFFFFFFF.
- Memory: ADDI x1,x0,0x40; ADDI x2,x0,0x7B; SW x2,0(x1); LW x3,0(x1); ADDI x4,x3,1 -> LW cycle alu_result 0x40, x4 result 0x7C.
- Branches: BEQ with equal operands at pc 0x10 with offset +12 -> next_pc 0x1C, sel_pc_src=1; BNE with equal operands -> next_pc 0x14, sel_pc_src=0.
- Jumps: JAL x1,+8 at pc 0x20 -> next_pc 0x28, x1=0x24; JALR x0,1(x1) -> next_pc 0x24 (bit 0 cleared).
- Edges: ADDI x0,x0,9 then ADD x1,x0,x0 -> x1=0; mid-run reset pulse -> pc=0 immediately without waiting for a clock edge; MUL with MAIN_MUL_EN, 7*6 -> 42; without MAIN_MUL_EN -> NOP.
